uart_oversampled_receiver: RTL and testbench

Robust serial receiver for the elevator controller's host link. Synchronises the asynchronous `rx` line, detects the start bit on a falling edge, and votes on three oversampled points per bit. It delivers 8N1 bytes to downstream logic through a valid/ready handshake, with framing-error and overrun reporting. It pairs with the existing UART transmitter at the same baud rate.

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_baud_tick.sv | 28 ++
 rtl/uart_oversampled_receiver.sv | 180 ++++++++++++++++++
 tb/tb_uart_oversampled_receiver.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, constants and helper functions
package uart_pkg;

  // Receiver state encoding
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_HIGH
  } rx_state_t;

  // Samples per bit; the 4-bit sample counter relies on this being 16
  localparam int OVERSAMPLE = 16;

  // Sample indices used for the majority vote, and the last sample of a bit
  localparam logic [3:0] SAMPLE_VOTE_A = 4'd7;
  localparam logic [3:0] SAMPLE_VOTE_B = 4'd8;
  localparam logic [3:0] SAMPLE_VOTE_C = 4'd9;
  localparam logic [3:0] SAMPLE_LAST   = 4'd15;

  // Clock cycles per oversample tick, truncated
  function automatic int DIV(input int clkfrq, input int baudrate, input int oversample);
    return clkfrq / (baudrate * oversample);
  endfunction

  // Two-out-of-three majority
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - oversample tick divider with synchronous clear
module uart_baud_tick #(
  parameter int DIV = 651
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam logic [15:0] CNT_TOP = 16'(DIV - 1);

  logic [15:0] cnt;

  assign tick = (cnt == CNT_TOP);

  // Count 0..DIV-1 and wrap; clear realigns the phase to the caller's event
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= 16'd0;
    end else if (tick) begin
      cnt <= 16'd0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/uart_oversampled_receiver.sv
// rtl/uart_oversampled_receiver.sv - 8N1 receiver with 3-point majority vote and valid/ready output
module uart_oversampled_receiver #(
  parameter int CLKFRQ     = 100000000,
  parameter int BAUDRATE   = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       en,
  output logic [7:0] data_out,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  import uart_pkg::*;

  localparam int DIV_VAL = DIV(CLKFRQ, BAUDRATE, OVERSAMPLE);

  rx_state_t  state, next_state;
  logic       rx_meta, rxs;
  logic       tick;
  logic       clear;
  logic [3:0] scnt;
  logic [2:0] bit_idx;
  logic [7:0] shreg;
  logic       samp_a, samp_b, bit_val;
  logic       vote;
  logic       shift_en;
  logic       stop_done;

  uart_baud_tick #(
    .DIV(DIV_VAL)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .clear(clear),
    .tick (tick)
  );

  // Vote for the current bit, valid on the tick of sample 9
  assign vote = majority3(samp_a, samp_b, rxs);
  assign busy = (state != ST_IDLE);

  // Two-flop synchroniser, idle-high so reset never looks like a start bit
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and datapath strobes
  always_comb begin
    next_state = state;
    clear      = 1'b0;
    shift_en   = 1'b0;
    stop_done  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (en && !rxs) begin
          next_state = ST_START;
          clear      = 1'b1;
        end
      end
      ST_START: begin
        if (tick && scnt == SAMPLE_LAST) begin
          next_state = bit_val ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick && scnt == SAMPLE_LAST) begin
          shift_en = 1'b1;
          if (bit_idx == 3'd7) begin
            next_state = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        // Decide early so a following start edge is not missed
        if (tick && scnt == SAMPLE_VOTE_C) begin
          stop_done  = 1'b1;
          next_state = vote ? ST_IDLE : ST_WAIT_HIGH;
        end
      end
      ST_WAIT_HIGH: begin
        if (rxs) begin
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Sample counter, realigned to the detected start edge
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      scnt <= 4'd0;
    end else if (tick) begin
      scnt <= scnt + 4'd1;
    end
  end

  // Capture the vote points and latch the decided bit at sample 9
  always_ff @(posedge clk) begin
    if (reset) begin
      samp_a  <= 1'b1;
      samp_b  <= 1'b1;
      bit_val <= 1'b1;
    end else if (tick) begin
      if (scnt == SAMPLE_VOTE_A) begin
        samp_a <= rxs;
      end
      if (scnt == SAMPLE_VOTE_B) begin
        samp_b <= rxs;
      end
      if (scnt == SAMPLE_VOTE_C) begin
        bit_val <= vote;
      end
    end
  end

  // Shift data bits in LSB first at the end of each data bit
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg   <= 8'h00;
      bit_idx <= 3'd0;
    end else if (clear) begin
      bit_idx <= 3'd0;
    end else if (shift_en) begin
      shreg   <= {bit_val, shreg[7:1]};
      bit_idx <= bit_idx + 3'd1;
    end
  end

  // Output byte, handshake and one-cycle status pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out  <= 8'h00;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (valid && ready) begin
        valid <= 1'b0;
      end
      if (stop_done) begin
        if (vote) begin
          // A byte consumed this cycle frees the slot for the new one
          if (!valid || ready) begin
            data_out <= shreg;
            valid    <= 1'b1;
          end else begin
            overrun <= 1'b1;
          end
        end else begin
          frame_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_oversampled_receiver.sv
// tb/tb_uart_oversampled_receiver.sv - directed self-checking bench for uart_oversampled_receiver
module tb_uart_oversampled_receiver;

  localparam int BIT_CLKS = 160;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       en;
  logic [7:0] data_out;
  logic       valid;
  logic       ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int checks = 0;
  int errors = 0;

  // Monitor state
  int         valid_cycles = 0;
  int         fe_cycles = 0;
  int         ov_cycles = 0;
  int         both_cycles = 0;
  int         busy_cycles = 0;
  int         n_log = 0;
  logic [7:0] data_log [0:63];
  logic       valid_q = 1'b0;

  uart_oversampled_receiver #(
    .CLKFRQ    (16000),
    .BAUDRATE  (100),
    .OVERSAMPLE(16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .en       (en),
    .data_out (data_out),
    .valid    (valid),
    .ready    (ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Count output events on the falling edge, log each new byte
  always @(negedge clk) begin
    if (valid) valid_cycles++;
    if (frame_err) fe_cycles++;
    if (overrun) ov_cycles++;
    if (frame_err && overrun) both_cycles++;
    if (busy) busy_cycles++;
    if (valid && !valid_q) begin
      data_log[n_log % 64] = data_out;
      n_log++;
    end
    valid_q = valid;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic v);
    rx = v;
    wait_clks(BIT_CLKS);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx    = 1'b1;
    en    = 1'b1;
    ready = 1'b1;
    wait_clks(3);
    reset = 1'b0;
    wait_clks(2);
    checks++;
    if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data: got %0h expected 00", data_out); end
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", valid); end
    checks++;
    if (frame_err !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL reset_flags: got fe=%0b ov=%0b expected 0 0", frame_err, overrun); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
  endtask

  task automatic test_single_byte();
    int fe0, ov0, n0;
    logic [7:0] b;
    b = 8'hA5;
    fe0 = fe_cycles; ov0 = ov_cycles; n0 = n_log;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    rx = 1'b1;
    // Stop sample 9 lands 103 clocks into the stop bit; valid follows that edge
    wait_clks(102);
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL single_early: got valid=%0b expected 0", valid); end
    wait_clks(1);
    checks++;
    if (valid !== 1'b1 || data_out !== 8'hA5) begin errors++; $display("FAIL single_data: got valid=%0b data=%0h expected 1 a5", valid, data_out); end
    wait_clks(1);
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL single_pulse: got valid=%0b expected 0", valid); end
    wait_clks(BIT_CLKS - 104 + 20);
    checks++;
    if (n_log - n0 !== 1 || fe_cycles - fe0 !== 0 || ov_cycles - ov0 !== 0) begin
      errors++; $display("FAIL single_counts: got bytes=%0d fe=%0d ov=%0d expected 1 0 0", n_log - n0, fe_cycles - fe0, ov_cycles - ov0);
    end
  endtask

  task automatic test_glitch();
    int fe0, ov0, n0;
    fe0 = fe_cycles; ov0 = ov_cycles; n0 = n_log;
    rx = 1'b0;
    wait_clks(20);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL glitch_start: got busy=%0b expected 1", busy); end
    wait_clks(20);
    rx = 1'b1;
    wait_clks(200);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL glitch_idle: got busy=%0b expected 0", busy); end
    checks++;
    if (n_log - n0 !== 0 || fe_cycles - fe0 !== 0 || ov_cycles - ov0 !== 0) begin
      errors++; $display("FAIL glitch_counts: got bytes=%0d fe=%0d ov=%0d expected 0 0 0", n_log - n0, fe_cycles - fe0, ov_cycles - ov0);
    end
  endtask

  task automatic test_bad_stop();
    int fe0, ov0, n0;
    fe0 = fe_cycles; ov0 = ov_cycles; n0 = n_log;
    send_frame(8'h3C, 1'b0);
    rx = 1'b0;
    wait_clks(400);
    checks++;
    if (fe_cycles - fe0 !== 1) begin errors++; $display("FAIL badstop_fe: got %0d cycles expected 1", fe_cycles - fe0); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL badstop_busy: got %0b expected 1", busy); end
    rx = 1'b1;
    wait_clks(5);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL badstop_release: got busy=%0b expected 0", busy); end
    checks++;
    if (n_log - n0 !== 0 || ov_cycles - ov0 !== 0) begin
      errors++; $display("FAIL badstop_counts: got bytes=%0d ov=%0d expected 0 0", n_log - n0, ov_cycles - ov0);
    end
    wait_clks(20);
  endtask

  task automatic test_overrun();
    int fe0, ov0, n0, b0;
    ready = 1'b0;
    wait_clks(5);
    fe0 = fe_cycles; ov0 = ov_cycles; n0 = n_log; b0 = both_cycles;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    wait_clks(20);
    checks++;
    if (valid !== 1'b1 || data_out !== 8'h11) begin errors++; $display("FAIL overrun_hold: got valid=%0b data=%0h expected 1 11", valid, data_out); end
    checks++;
    if (ov_cycles - ov0 !== 1) begin errors++; $display("FAIL overrun_pulse: got %0d cycles expected 1", ov_cycles - ov0); end
    checks++;
    if (fe_cycles - fe0 !== 0 || both_cycles - b0 !== 0 || n_log - n0 !== 1) begin
      errors++; $display("FAIL overrun_counts: got fe=%0d both=%0d bytes=%0d expected 0 0 1", fe_cycles - fe0, both_cycles - b0, n_log - n0);
    end
    ready = 1'b1;
    checks++;
    if (valid !== 1'b1) begin errors++; $display("FAIL overrun_ready0: got valid=%0b expected 1", valid); end
    wait_clks(1);
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL overrun_ready1: got valid=%0b expected 0", valid); end
    wait_clks(10);
  endtask

  task automatic test_back_to_back();
    int ov0, n0;
    ov0 = ov_cycles; n0 = n_log;
    send_frame(8'h12, 1'b1);
    send_frame(8'h34, 1'b1);
    wait_clks(20);
    checks++;
    if (n_log - n0 !== 2) begin errors++; $display("FAIL b2b_count: got %0d bytes expected 2", n_log - n0); end
    else begin
      checks++;
      if (data_log[n0 % 64] !== 8'h12 || data_log[(n0 + 1) % 64] !== 8'h34) begin
        errors++; $display("FAIL b2b_data: got %0h %0h expected 12 34", data_log[n0 % 64], data_log[(n0 + 1) % 64]);
      end
    end
    checks++;
    if (ov_cycles - ov0 !== 0) begin errors++; $display("FAIL b2b_overrun: got %0d expected 0", ov_cycles - ov0); end
  endtask

  task automatic test_noisy_bit();
    int fe0, n0;
    fe0 = fe_cycles; n0 = n_log;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        // Low for one tick period around sample 8 only; samples 7 and 9 stay high
        rx = 1'b1;
        wait_clks(87);
        rx = 1'b0;
        wait_clks(10);
        rx = 1'b1;
        wait_clks(BIT_CLKS - 97);
      end else begin
        send_bit(1'b1);
      end
    end
    send_bit(1'b1);
    wait_clks(20);
    checks++;
    if (n_log - n0 !== 1 || data_log[n0 % 64] !== 8'hFF) begin
      errors++; $display("FAIL noisy_data: got bytes=%0d data=%0h expected 1 ff", n_log - n0, data_log[n0 % 64]);
    end
    checks++;
    if (fe_cycles - fe0 !== 0) begin errors++; $display("FAIL noisy_fe: got %0d expected 0", fe_cycles - fe0); end
  endtask

  task automatic test_reset_enable();
    int n0, bz0, fe0;
    logic [7:0] b;
    b = 8'h5A;
    n0 = n_log;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(b[i]);
    rx = b[4];
    wait_clks(80);
    reset = 1'b1;
    wait_clks(1);
    checks++;
    if (data_out !== 8'h00 || valid !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL midreset_outputs: got data=%0h v=%0b fe=%0b ov=%0b busy=%0b expected 00 0 0 0 0", data_out, valid, frame_err, overrun, busy);
    end
    wait_clks(1);
    reset = 1'b0;
    rx = 1'b1;
    wait_clks(400);
    checks++;
    if (n_log - n0 !== 0 || busy !== 1'b0) begin errors++; $display("FAIL midreset_novalid: got bytes=%0d busy=%0b expected 0 0", n_log - n0, busy); end

    en = 1'b0;
    n0 = n_log; bz0 = busy_cycles; fe0 = fe_cycles;
    send_frame(8'h96, 1'b1);
    wait_clks(20);
    checks++;
    if (n_log - n0 !== 0 || busy_cycles - bz0 !== 0 || fe_cycles - fe0 !== 0) begin
      errors++; $display("FAIL disabled: got bytes=%0d busy=%0d fe=%0d expected 0 0 0", n_log - n0, busy_cycles - bz0, fe_cycles - fe0);
    end

    en = 1'b1;
    n0 = n_log;
    send_frame(8'hC3, 1'b1);
    wait_clks(20);
    checks++;
    if (n_log - n0 !== 1 || data_log[n0 % 64] !== 8'hC3) begin
      errors++; $display("FAIL enabled_data: got bytes=%0d data=%0h expected 1 c3", n_log - n0, data_log[n0 % 64]);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_glitch();
    test_bad_stop();
    test_overrun();
    test_back_to_back();
    test_noisy_bit();
    test_reset_enable();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
